// File: rtl/float_pkg.sv
// ============================================================================
// Module   : float_pkg
// Brief    : Shared float-format helpers: bias, field positions and classes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package float_pkg;

    typedef enum logic [1:0] {
        FC_NUMBER = 2'd0,
        FC_INF    = 2'd1,
        FC_NAN    = 2'd2
    } floatClass_t;

    function automatic int calcBias(input int expSize);
        return (1 << (expSize - 1)) - 1;
    endfunction

    function automatic int mantissaLsb();
        return 0;
    endfunction

    function automatic int exponentLsb(input int mantSize);
        return mantSize;
    endfunction

    function automatic int signPos(input int mantSize, input int expSize);
        return mantSize + expSize;
    endfunction

    function automatic int expAllOnes(input int expSize);
        return (1 << expSize) - 1;
    endfunction

    function automatic logic isNaN(input logic expIsOnes, input logic mantIsZero);
        return expIsOnes && !mantIsZero;
    endfunction

    function automatic logic isInf(input logic expIsOnes, input logic mantIsZero);
        return expIsOnes && mantIsZero;
    endfunction

    function automatic floatClass_t classify(input logic expIsOnes, input logic mantIsZero);
        if (isNaN(expIsOnes, mantIsZero)) return FC_NAN;
        if (isInf(expIsOnes, mantIsZero)) return FC_INF;
        return FC_NUMBER;
    endfunction

endpackage

`default_nettype wire

// File: rtl/float_unpack.sv
// ============================================================================
// Module   : float_unpack
// Brief    : Combinational split of a float into sign, magnitude, exponent, class.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_unpack
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE = 23,
    parameter int EXPONENT_SIZE = 8
) (
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] floatIn,
    output logic                                 sign,
    output logic [MANTISSA_SIZE:0]               magnitude,
    output logic signed [EXPONENT_SIZE+1:0]      effExp,
    output floatClass_t                          fclass
);

    localparam int c_SIGN_POS = signPos(MANTISSA_SIZE, EXPONENT_SIZE);
    localparam int c_EXP_LSB  = exponentLsb(MANTISSA_SIZE);
    localparam int c_MAN_LSB  = mantissaLsb();
    localparam logic [EXPONENT_SIZE-1:0] c_EXP_ONES   = EXPONENT_SIZE'(expAllOnes(EXPONENT_SIZE));
    localparam logic [EXPONENT_SIZE+1:0] c_BIAS_W     = (EXPONENT_SIZE+2)'(calcBias(EXPONENT_SIZE));
    localparam logic [EXPONENT_SIZE+1:0] c_DENORM_EXP = (EXPONENT_SIZE+2)'(1 - calcBias(EXPONENT_SIZE));

    logic [EXPONENT_SIZE-1:0] w_exp;
    logic [MANTISSA_SIZE-1:0] w_mant;
    logic                     w_expZero;

    assign w_exp     = floatIn[c_EXP_LSB +: EXPONENT_SIZE];
    assign w_mant    = floatIn[c_MAN_LSB +: MANTISSA_SIZE];
    assign sign      = floatIn[c_SIGN_POS];
    assign w_expZero = (w_exp == '0);

    // Denormals share the smallest normal exponent but lose the hidden bit
    assign magnitude = {!w_expZero, w_mant};
    assign effExp    = signed'(w_expZero ? c_DENORM_EXP : ({2'b00, w_exp} - c_BIAS_W));
    assign fclass    = classify(w_exp == c_EXP_ONES, w_mant == '0);

endmodule

`default_nettype wire

// File: rtl/float_to_fixed.sv
// ============================================================================
// Module   : float_to_fixed
// Brief    : 3-stage float to signed fixed-point converter with valid/ready.
//            Optional sticky flags: FLOAT_TO_FIXED_STICKY_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_to_fixed
    import float_pkg::*;
#(
    parameter int MANTISSA_SIZE       = 23,
    parameter int EXPONENT_SIZE       = 8,
    parameter int INT_SIZE            = 16,
    parameter int FRAC_SIZE           = 16,
    parameter int ENABLE_OPTIMIZATION = 0
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] floatIn,
    input  logic                                 inValid,
    output logic                                 inReady,
    output logic [INT_SIZE+FRAC_SIZE-1:0]        fixedOut,
    output logic                                 outValid,
    input  logic                                 outReady,
    output logic                                 overflow,
    output logic                                 nan,
    input  logic                                 clearFlags,
    output logic                                 stickyOverflow,
    output logic                                 stickyNan
);

    localparam int c_W   = INT_SIZE + FRAC_SIZE;
    localparam int c_SHW = EXPONENT_SIZE + 2;
    localparam int c_MW  = MANTISSA_SIZE + 1;
    localparam logic signed [c_SHW-1:0] c_SH_OFS  = c_SHW'(FRAC_SIZE - MANTISSA_SIZE);
    localparam logic signed [c_SHW-1:0] c_SH_MAX  = c_SHW'(c_W - MANTISSA_SIZE);
    localparam logic [c_SHW-1:0]        c_RSH_MAX = c_SHW'(c_MW);
    localparam logic [c_W:0]            c_POS_MAX = {2'b00, {(c_W-1){1'b1}}};
    localparam logic [c_W:0]            c_NEG_MAX = {2'b01, {(c_W-1){1'b0}}};
    localparam logic [c_W-1:0]          c_FIX_MAX = {1'b0, {(c_W-1){1'b1}}};
    localparam logic [c_W-1:0]          c_FIX_MIN = {1'b1, {(c_W-1){1'b0}}};

    logic w_adv;
    assign w_adv   = !outValid || outReady;
    assign inReady = w_adv;

    // S1: unpack
    logic                     w_sign;
    logic [c_MW-1:0]          w_mag;
    logic signed [c_SHW-1:0]  w_effExp;
    logic signed [c_SHW-1:0]  w_sh;
    floatClass_t              w_class;

    float_unpack #(
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE)
    ) u_unpack (
        .floatIn   (floatIn),
        .sign      (w_sign),
        .magnitude (w_mag),
        .effExp    (w_effExp),
        .fclass    (w_class)
    );

    assign w_sh = w_effExp + c_SH_OFS;

    logic                     r_s1Valid;
    logic                     r_s1Sign;
    logic [c_MW-1:0]          r_s1Mag;
    logic signed [c_SHW-1:0]  r_s1Sh;
    floatClass_t              r_s1Class;

    // S2: shift and round
    logic [c_SHW-1:0] w_rsh;
    logic [c_MW:0]    w_rext;
    logic [c_W:0]     w_magRaw;
    logic [c_W:0]     w_magRnd;
    logic             w_guard;
    logic             w_roundBit;
    logic             w_preOvf;

    assign w_rsh  = -r_s1Sh;
    // Extra LSB collects the last bit shifted out, which is the guard bit
    assign w_rext = {r_s1Mag, 1'b0} >> w_rsh;

    always_comb begin
        w_magRaw = '0;
        w_guard  = 1'b0;
        w_preOvf = 1'b0;
        if (!r_s1Sh[c_SHW-1]) begin
            w_preOvf = (r_s1Sh > c_SH_MAX);
            w_magRaw = (c_W+1)'(r_s1Mag) << unsigned'(r_s1Sh);
        end else if (w_rsh <= c_RSH_MAX) begin
            w_magRaw = (c_W+1)'(w_rext[c_MW:1]);
            w_guard  = w_rext[0];
        end
    end

    generate
        if (ENABLE_OPTIMIZATION != 0) begin : g_truncate
            assign w_roundBit = 1'b0;
        end else begin : g_round
            assign w_roundBit = w_guard;
        end
    endgenerate

    assign w_magRnd = w_magRaw + (c_W+1)'(w_roundBit);

    logic             r_s2Valid;
    logic             r_s2Sign;
    logic [c_W:0]     r_s2Mag;
    logic             r_s2PreOvf;
    floatClass_t      r_s2Class;

    // S3: sign and saturate; a negative magnitude of exactly 2**(W-1) is representable
    logic             w_sat;
    logic [c_W-1:0]   w_fixed;
    logic             w_ovf;
    logic             w_nan;

    assign w_sat = r_s2PreOvf || (r_s2Class == FC_INF) ||
                   (r_s2Sign ? (r_s2Mag > c_NEG_MAX) : (r_s2Mag > c_POS_MAX));

    always_comb begin
        w_fixed = r_s2Sign ? -r_s2Mag[c_W-1:0] : r_s2Mag[c_W-1:0];
        w_ovf   = 1'b0;
        w_nan   = 1'b0;
        if (r_s2Class == FC_NAN) begin
            w_fixed = '0;
            w_nan   = 1'b1;
        end else if (w_sat) begin
            w_fixed = r_s2Sign ? c_FIX_MIN : c_FIX_MAX;
            w_ovf   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1Valid  <= 1'b0;
            r_s1Sign   <= 1'b0;
            r_s1Mag    <= '0;
            r_s1Sh     <= '0;
            r_s1Class  <= FC_NUMBER;
            r_s2Valid  <= 1'b0;
            r_s2Sign   <= 1'b0;
            r_s2Mag    <= '0;
            r_s2PreOvf <= 1'b0;
            r_s2Class  <= FC_NUMBER;
            outValid   <= 1'b0;
            fixedOut   <= '0;
            overflow   <= 1'b0;
            nan        <= 1'b0;
        end else if (w_adv) begin
            r_s1Valid  <= inValid;
            r_s1Sign   <= w_sign;
            r_s1Mag    <= w_mag;
            r_s1Sh     <= w_sh;
            r_s1Class  <= w_class;
            r_s2Valid  <= r_s1Valid;
            r_s2Sign   <= r_s1Sign;
            r_s2Mag    <= w_magRnd;
            r_s2PreOvf <= w_preOvf;
            r_s2Class  <= r_s1Class;
            outValid   <= r_s2Valid;
            fixedOut   <= w_fixed;
            overflow   <= w_ovf;
            nan        <= w_nan;
        end
    end

`ifdef FLOAT_TO_FIXED_STICKY_FLAGS_EN
    logic r_stickyOvf;
    logic r_stickyNan;
    logic w_xferOut;

    assign w_xferOut = outValid && outReady;

    // A flag being set on the same edge as a clear takes priority
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stickyOvf <= 1'b0;
            r_stickyNan <= 1'b0;
        end else begin
            if (w_xferOut && overflow) r_stickyOvf <= 1'b1;
            else if (clearFlags)       r_stickyOvf <= 1'b0;
            if (w_xferOut && nan)      r_stickyNan <= 1'b1;
            else if (clearFlags)       r_stickyNan <= 1'b0;
        end
    end

    assign stickyOverflow = r_stickyOvf;
    assign stickyNan      = r_stickyNan;
`else
    logic w_unusedClear;
    assign w_unusedClear  = clearFlags;
    assign stickyOverflow = 1'b0;
    assign stickyNan      = 1'b0;
`endif

endmodule

`default_nettype wire
